commit_stage: RTL

COMMIT_STAGE -- requirements
Module: commit_stage

---
 rtl/commit_stage_pkg.sv | 40 ++++
 rtl/config_pkg.sv | 6 +
 rtl/commit_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/commit_stage_pkg.sv
// Shared backend types: functional-unit encoding, trap record, scoreboard entry.
package commit_stage_pkg;

    import config_pkg::*;

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        FU_ALU    = 3'd1,
        FU_BRANCH = 3'd2,
        FU_LOAD   = 3'd3,
        FU_STORE  = 3'd4,
        FU_MULT   = 3'd5,
        FU_CSR    = 3'd6
    } fu_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic [XLEN-1:0] pc;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fu_t             fu;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic            valid;
        exception_t      ex;
    } scoreboard_entry_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_STORE = 2'd1,
        ST_FLUSH      = 2'd2
    } commit_state_t;

    localparam exception_t EXC_NONE = '0;

endpackage

// File: rtl/config_pkg.sv
// Global core configuration shared by every backend block.
package config_pkg;

    localparam int unsigned XLEN = 32;

endpackage

// File: rtl/commit_stage.sv
// In-order commit: retires the scoreboard head, drives the GPR write port,
// sequences stores through the LSU and raises traps / pipeline flushes.
module commit_stage
    import commit_stage_pkg::*;
#(
    parameter int unsigned XLEN = config_pkg::XLEN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              halt_i,
    input  scoreboard_entry_t commit_instr_i,
    output logic              commit_ack_o,
    output logic [4:0]        waddr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              we_gpr_o,
    output logic              commit_store_o,
    input  logic              store_done_i,
    output logic              csr_commit_o,
    output exception_t        ex_o,
    output logic              flush_o,
    output logic [63:0]       instret_o
);

    commit_state_t r_state;
    commit_state_t w_next_state;
    exception_t    r_ex;
    logic [63:0]   r_instret;
    logic          w_candidate;
    logic          w_take_exc;
    logic          w_count;
    logic          w_rd_nonzero;
    logic          w_unused;

    // The trap pc is taken from the entry itself; the copy inside ex is redundant.
    assign w_unused     = ^commit_instr_i.ex.pc;
    assign w_candidate  = commit_instr_i.valid & ~halt_i & ~flush_i & ~rst_i;
    assign w_rd_nonzero = (commit_instr_i.rd != 5'd0);
    assign waddr_o      = commit_instr_i.rd;
    assign wdata_o      = XLEN'(commit_instr_i.result);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RUN;
            r_ex      <= EXC_NONE;
            r_instret <= 64'd0;
        end else begin
            r_state  <= w_next_state;
            r_ex.valid <= w_take_exc;
            if (w_take_exc) begin
                r_ex.cause <= commit_instr_i.ex.cause;
                r_ex.tval  <= commit_instr_i.ex.tval;
                r_ex.pc    <= commit_instr_i.pc;
            end
            if (w_count) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    // Reset and external flush dominate; otherwise an exception outranks the fu type.
    always_comb begin
        w_next_state   = r_state;
        commit_ack_o   = 1'b0;
        we_gpr_o       = 1'b0;
        commit_store_o = 1'b0;
        csr_commit_o   = 1'b0;
        flush_o        = 1'b0;
        w_take_exc     = 1'b0;
        w_count        = 1'b0;
        if (rst_i || flush_i) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_candidate) begin
                        if (commit_instr_i.ex.valid) begin
                            commit_ack_o = 1'b1;
                            w_take_exc   = 1'b1;
                            w_next_state = ST_FLUSH;
                        end else begin
                            case (commit_instr_i.fu)
                                FU_STORE: begin
                                    commit_store_o = 1'b1;
                                    w_next_state   = ST_WAIT_STORE;
                                end
                                FU_CSR: begin
                                    csr_commit_o = 1'b1;
                                    commit_ack_o = 1'b1;
                                    we_gpr_o     = w_rd_nonzero;
                                    w_count      = 1'b1;
                                    w_next_state = ST_FLUSH;
                                end
                                default: begin
                                    commit_ack_o = 1'b1;
                                    we_gpr_o     = w_rd_nonzero;
                                    w_count      = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_WAIT_STORE: begin
                    if (store_done_i) begin
                        commit_ack_o = 1'b1;
                        w_count      = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush_o      = 1'b1;
                    w_next_state = ST_RUN;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    assign ex_o      = r_ex;
    assign instret_o = r_instret;

endmodule
